// File: rtl/seq_sub64.sv
// Multi-cycle subtractor d = a - b - bin, one SLICE-bit chunk per clock, LSB first; done pulses WIDTH/SLICE+1 cycles after start.
// No backpressure: start is accepted only in IDLE or DONE and ignored while busy; the result is held until the next accepted start.
module seq_sub64 #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } opnd_t;

  state_t          state;
  opnd_t           op;
  logic            c;
  logic [CW-1:0]   cnt;

  logic [SLICE-1:0] a_chunk;
  logic [SLICE-1:0] b_chunk;
  logic [SLICE:0]   sum;
  logic             ovf_next;

  // Subtraction as a + ~b + ~bin; the carry out of each chunk feeds the next.
  always_comb begin
    a_chunk  = op.a[cnt*SLICE +: SLICE];
    b_chunk  = op.b[cnt*SLICE +: SLICE];
    sum      = {1'b0, a_chunk} + {1'b0, ~b_chunk} + {{SLICE{1'b0}}, c};
    ovf_next = (op.a[WIDTH-1] != op.b[WIDTH-1]) && (sum[SLICE-1] != op.a[WIDTH-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op    <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      d     <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            op.a  <= a;
            op.b  <= b;
            c     <= ~bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          d[cnt*SLICE +: SLICE] <= sum[SLICE-1:0];
          c   <= sum[SLICE];
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            bout  <= ~sum[SLICE];
            ovf   <= ovf_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
